chimera_pmu_ctrl: RTL and testbench

APB-attached power-management sequencer for the external cluster domain. It consumes the APB request emitted by the top wrapper's external-config bridge and returns the APB response. It drives the per-cluster reset, clock-gate and isolation controls back into the wrapper, using the isolation acknowledges from the cluster domain. One independent power FSM per cluster orders clock-enable, reset-release and de-isolation on power-up, and reverses that order on power-down, with a timeout on isolation handshakes.

---
 rtl/chimera_pmu_pkg.sv | 21 ++
 rtl/chimera_pmu_ctrl_if.sv | 11 +
 rtl/chimera_pmu_ctrl.sv | 161 ++++++++++++++++
 tb/tb_chimera_pmu_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/chimera_pmu_pkg.sv
// Shared APB request/response types for the chimera PMU sequencer.
// The wrapper bridge and the PMU both use these layouts.
package chimera_pmu_pkg;

    typedef struct packed {
        logic [31:0] paddr;
        logic [2:0]  pprot;
        logic        psel;
        logic        penable;
        logic        pwrite;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
    } apb_req_t;

    typedef struct packed {
        logic        pready;
        logic [31:0] prdata;
        logic        pslverr;
    } apb_rsp_t;

endpackage

// File: rtl/chimera_pmu_ctrl_if.sv
// APB request/response bundle between the external-config bridge and the PMU.
// The master side drives requests and the slave side returns responses.
interface chimera_pmu_ctrl_if;
    import chimera_pmu_pkg::*;

    apb_req_t req;
    apb_rsp_t rsp;

    modport master (output req, input rsp);
    modport slave  (input req, output rsp);
endinterface

// File: rtl/chimera_pmu_ctrl.sv
// APB-controlled power sequencer with one clock/reset/isolation FSM per cluster.
// Power-up order is clock, reset, isolation; power-down runs in the reverse order.
module chimera_pmu_ctrl #(
    parameter int unsigned NumClusters = 5,
    parameter int unsigned ClkCycles   = 4,
    parameter int unsigned RstCycles   = 4,
    parameter int unsigned IsoTimeout  = 255,
    parameter type apb_req_t = chimera_pmu_pkg::apb_req_t,
    parameter type apb_rsp_t = chimera_pmu_pkg::apb_rsp_t
) (
    input  logic                   soc_clk_i,
    input  logic                   rst_ni,
    input  apb_req_t               apb_req_i,
    output apb_rsp_t               apb_rsp_o,
    output logic [NumClusters-1:0] pmu_rst_clusters_no,
    output logic [NumClusters-1:0] pmu_clkgate_en_clusters_o,
    output logic [NumClusters-1:0] pmu_iso_en_clusters_o,
    input  logic [NumClusters-1:0] pmu_iso_ack_clusters_i
);

    localparam logic [3:0] AddrTarget = 4'h0;
    localparam logic [3:0] AddrStatus = 4'h4;
    localparam logic [3:0] AddrErr    = 4'h8;

    localparam logic [7:0] ClkLoad = 8'(ClkCycles - 1);
    localparam logic [7:0] RstLoad = 8'(RstCycles - 1);
    localparam logic [7:0] IsoLoad = 8'(IsoTimeout);

    typedef enum logic [2:0] {
        StOff,
        StPuClk,
        StPuRst,
        StPuIso,
        StOn,
        StPdIso,
        StPdRst,
        StPdClk
    } state_e;

    state_e                 state_q [NumClusters];
    logic [7:0]             cnt_q   [NumClusters];
    logic [NumClusters-1:0] target_q;
    logic [NumClusters-1:0] err_q;
    logic [31:0]            status_w;
    logic                   apb_wr;
    logic                   target_we;
    logic                   err_we;
    logic [NumClusters-1:0] wdata_w;
    logic                   unused_req;

    assign apb_wr    = apb_req_i.psel & apb_req_i.penable & apb_req_i.pwrite;
    assign target_we = apb_wr && (apb_req_i.paddr[3:0] == AddrTarget);
    assign err_we    = apb_wr && (apb_req_i.paddr[3:0] == AddrErr);
    assign wdata_w   = apb_req_i.pwdata[NumClusters-1:0];

    // Upper address bits, protection and strobes carry no meaning for this block.
    assign unused_req = ^{apb_req_i.paddr[31:4], apb_req_i.pprot, apb_req_i.pstrb,
                          apb_req_i.pwdata[31:NumClusters]};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        status_w = '0;
        for (int i = 0; i < NumClusters; i++) begin
            status_w[i]      = (state_q[i] == StOn);
            status_w[16 + i] = (state_q[i] != StOn) && (state_q[i] != StOff);
        end
    end

    always_comb begin
        apb_rsp_o        = '0;
        apb_rsp_o.pready = apb_req_i.psel;
        unique case (apb_req_i.paddr[3:0])
            AddrTarget: apb_rsp_o.prdata = 32'(target_q);
            AddrStatus: begin
                apb_rsp_o.prdata  = status_w;
                apb_rsp_o.pslverr = apb_req_i.psel & apb_req_i.pwrite;
            end
            AddrErr:    apb_rsp_o.prdata = 32'(err_q);
            default:    apb_rsp_o.pslverr = apb_req_i.psel;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge soc_clk_i) begin
        if (!rst_ni) begin
            target_q                  <= '0;
            err_q                     <= '0;
            pmu_rst_clusters_no       <= '0;
            pmu_clkgate_en_clusters_o <= '1;
            pmu_iso_en_clusters_o     <= '1;
            // NOTE: the per-cluster state and counter arrays are tiny flops, not RAM,
            // so they are reset like any other register.
            for (int i = 0; i < NumClusters; i++) begin
                state_q[i] <= StOff;
                cnt_q[i]   <= '0;
            end
        end else begin
            if (target_we) target_q <= wdata_w;
            if (err_we)    err_q    <= err_q & ~wdata_w;

            // Timeout sets below come after the W1C so a same-cycle set wins.
            for (int i = 0; i < NumClusters; i++) begin
                unique case (state_q[i])
                    StOff: if (target_q[i]) begin
                        state_q[i]                   <= StPuClk;
                        pmu_clkgate_en_clusters_o[i] <= 1'b0;
                        cnt_q[i]                     <= ClkLoad;
                    end
                    StPuClk: if (cnt_q[i] == '0) begin
                        state_q[i]             <= StPuRst;
                        pmu_rst_clusters_no[i] <= 1'b1;
                        cnt_q[i]               <= RstLoad;
                    end else begin
                        cnt_q[i] <= cnt_q[i] - 8'd1;
                    end
                    StPuRst: if (cnt_q[i] == '0) begin
                        state_q[i]               <= StPuIso;
                        pmu_iso_en_clusters_o[i] <= 1'b0;
                        cnt_q[i]                 <= IsoLoad;
                    end else begin
                        cnt_q[i] <= cnt_q[i] - 8'd1;
                    end
                    StPuIso: if (!pmu_iso_ack_clusters_i[i] || cnt_q[i] == '0) begin
                        state_q[i] <= StOn;
                        if (pmu_iso_ack_clusters_i[i]) err_q[i] <= 1'b1;
                    end else begin
                        cnt_q[i] <= cnt_q[i] - 8'd1;
                    end
                    StOn: if (!target_q[i]) begin
                        state_q[i]               <= StPdIso;
                        pmu_iso_en_clusters_o[i] <= 1'b1;
                        cnt_q[i]                 <= IsoLoad;
                    end
                    StPdIso: if (pmu_iso_ack_clusters_i[i] || cnt_q[i] == '0) begin
                        state_q[i]             <= StPdRst;
                        pmu_rst_clusters_no[i] <= 1'b0;
                        cnt_q[i]               <= RstLoad;
                        if (!pmu_iso_ack_clusters_i[i]) err_q[i] <= 1'b1;
                    end else begin
                        cnt_q[i] <= cnt_q[i] - 8'd1;
                    end
                    StPdRst: if (cnt_q[i] == '0) begin
                        state_q[i]                   <= StPdClk;
                        pmu_clkgate_en_clusters_o[i] <= 1'b1;
                        cnt_q[i]                     <= ClkLoad;
                    end else begin
                        cnt_q[i] <= cnt_q[i] - 8'd1;
                    end
                    StPdClk: if (cnt_q[i] == '0) begin
                        state_q[i] <= StOff;
                    end else begin
                        cnt_q[i] <= cnt_q[i] - 8'd1;
                    end
                    default: state_q[i] <= StOff;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_chimera_pmu_ctrl.sv
// Directed bench for chimera_pmu_ctrl: expected values are queued when stimulus
// is applied and popped when the matching DUT observation is taken.
module tb_chimera_pmu_ctrl;
    import chimera_pmu_pkg::*;

    localparam int N = 5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] rst_no, gate, iso, ack;
    logic [N-1:0] a1 = '1, a2 = '1, a3 = '1;
    logic [N-1:0] stuck0 = '0;
    int           cyc = 0;
    int           viol = 0;
    int           checks = 0;
    int           errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    chimera_pmu_ctrl_if apb_if ();

    chimera_pmu_ctrl #(.NumClusters(N)) dut (
        .soc_clk_i                 (clk),
        .rst_ni                    (rst_n),
        .apb_req_i                 (apb_if.req),
        .apb_rsp_o                 (apb_if.rsp),
        .pmu_rst_clusters_no       (rst_no),
        .pmu_clkgate_en_clusters_o (gate),
        .pmu_iso_en_clusters_o     (iso),
        .pmu_iso_ack_clusters_i    (ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Cluster model: ack follows iso three cycles late unless forced low.
    always @(negedge clk) begin
        a1 <= iso;
        a2 <= a1;
        a3 <= a2;
    end
    assign ack = a3 & ~stuck0;

    // Order invariant: de-isolated implies out of reset, out of reset implies clock running.
    always @(negedge clk) begin
        if (rst_n && (((~iso & ~rst_no) | (rst_no & gate)) != '0)) viol++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %0h required none", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
        end
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic err, output logic rdy);
        apb_if.req.paddr   = addr;
        apb_if.req.pwrite  = 1'b0;
        apb_if.req.psel    = 1'b1;
        apb_if.req.penable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        apb_if.req.penable = 1'b1;
        data = apb_if.rsp.prdata;
        err  = apb_if.rsp.pslverr;
        rdy  = apb_if.rsp.pready;
        @(posedge clk);
        @(negedge clk);
        apb_if.req.psel    = 1'b0;
        apb_if.req.penable = 1'b0;
    endtask

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data,
                             output logic err, output int e);
        apb_if.req.paddr   = addr;
        apb_if.req.pwdata  = data;
        apb_if.req.pwrite  = 1'b1;
        apb_if.req.psel    = 1'b1;
        apb_if.req.penable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        apb_if.req.penable = 1'b1;
        err = apb_if.rsp.pslverr;
        @(posedge clk);
        @(negedge clk);
        apb_if.req.psel    = 1'b0;
        apb_if.req.penable = 1'b0;
        apb_if.req.pwrite  = 1'b0;
        e = cyc;
    endtask

    function automatic logic [N-1:0] out_sel(input int which);
        case (which)
            0:       return rst_no;
            1:       return gate;
            default: return iso;
        endcase
    endfunction

    task automatic wait_out(input int which, input int idx, input logic val,
                            input int budget, output int at);
        logic [N-1:0] v;
        at = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            v = out_sel(which);
            if (v[idx] === val) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic poll_status(input logic [31:0] want, input int budget, output int at);
        at = -1;
        apb_if.req.paddr   = 32'h4;
        apb_if.req.pwrite  = 1'b0;
        apb_if.req.penable = 1'b0;
        apb_if.req.psel    = 1'b1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (apb_if.rsp.prdata === want) begin
                at = cyc;
                break;
            end
        end
        apb_if.req.psel = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        err, rdy;
        int          e, e1, at;

        apb_if.req = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        expect_val("reset_rst_no", 32'h00); check(32'(rst_no));
        expect_val("reset_gate",   32'h1f); check(32'(gate));
        expect_val("reset_iso",    32'h1f); check(32'(iso));
        rst_n = 1'b1;
        @(negedge clk);
        expect_val("reset_target", 32'h0); apb_read(32'h0, rd, err, rdy); check(rd);
        expect_val("reset_status", 32'h0); apb_read(32'h4, rd, err, rdy); check(rd);
        expect_val("reset_err",    32'h0); apb_read(32'h8, rd, err, rdy); check(rd);

        // Power up cluster 0 with a well-behaved ack
        apb_write(32'h0, 32'h1, err, e);
        expect_val("pu_target_pslverr", 32'h0); check(32'(err));
        expect_val("pu_gate0_fall", 32'(e + 1));
        expect_val("pu_rst0_rise",  32'(e + 5));
        expect_val("pu_iso0_fall",  32'(e + 9));
        expect_val("pu_status_on",  32'(e + 12));
        wait_out(1, 0, 1'b0, 50, at); check(32'(at));
        wait_out(0, 0, 1'b1, 50, at); check(32'(at));
        wait_out(2, 0, 1'b0, 50, at); check(32'(at));
        poll_status(32'h1, 30, at); check(32'(at));
        expect_val("pu_err", 32'h0); apb_read(32'h8, rd, err, rdy); check(rd);

        // Power down with ack stuck low: isolation timeout
        stuck0[0] = 1'b1;
        apb_write(32'h0, 32'h0, err, e);
        expect_val("pd_iso0_rise",  32'(e + 1));
        expect_val("pd_rst0_fall",  32'(e + 257));
        expect_val("pd_err_set",    32'h1);
        expect_val("pd_gate0_rise", 32'(e + 261));
        expect_val("pd_status_off", 32'h0);
        expect_val("pd_err_clear",  32'h0);
        wait_out(2, 0, 1'b1, 10, at);  check(32'(at));
        wait_out(0, 0, 1'b0, 300, at); check(32'(at));
        apb_read(32'h8, rd, err, rdy); check(rd);
        wait_out(1, 0, 1'b1, 20, at);  check(32'(at));
        repeat (6) @(negedge clk);
        apb_read(32'h4, rd, err, rdy); check(rd);
        apb_write(32'h8, 32'h1, err, e);
        apb_read(32'h8, rd, err, rdy); check(rd);
        stuck0[0] = 1'b0;
        repeat (5) @(negedge clk);

        // All clusters up, then down two cycles later
        apb_write(32'h0, 32'h1f, err, e1);
        apb_write(32'h0, 32'h0, err, e);
        expect_val("all_on_edge",  32'(e1 + 12));
        expect_val("all_off_edge", 32'(e1 + 24));
        expect_val("all_rst_no",   32'h00);
        expect_val("all_gate",     32'h1f);
        expect_val("all_iso",      32'h1f);
        poll_status(32'h1f, 60, at); check(32'(at));
        poll_status(32'h0, 60, at);  check(32'(at));
        check(32'(rst_no));
        check(32'(gate));
        check(32'(iso));
        repeat (5) @(negedge clk);

        // Synchronous reset while cluster 2 sits in PU_RST
        apb_write(32'h0, 32'h4, err, e);
        expect_val("rst_mid_rst2_rise", 32'(e + 5));
        expect_val("rst_mid_rst_no",    32'h00);
        expect_val("rst_mid_gate",      32'h1f);
        expect_val("rst_mid_iso",       32'h1f);
        expect_val("rst_mid_target",    32'h0);
        wait_out(0, 2, 1'b1, 20, at); check(32'(at));
        rst_n = 1'b0;
        @(negedge clk);
        check(32'(rst_no));
        check(32'(gate));
        check(32'(iso));
        rst_n = 1'b1;
        @(negedge clk);
        apb_read(32'h0, rd, err, rdy); check(rd);

        // Error responses
        expect_val("bad_rd_prdata",  32'h0);
        expect_val("bad_rd_pslverr", 32'h1);
        expect_val("bad_rd_pready",  32'h1);
        apb_read(32'hc, rd, err, rdy);
        check(rd);
        check(32'(err));
        check(32'(rdy));
        expect_val("status_wr_pslverr", 32'h1);
        expect_val("status_wr_target",  32'h0);
        expect_val("status_wr_status",  32'h0);
        expect_val("status_wr_err",     32'h0);
        apb_write(32'h4, 32'hffff_ffff, err, e);
        check(32'(err));
        apb_read(32'h0, rd, err, rdy); check(rd);
        apb_read(32'h4, rd, err, rdy); check(rd);
        apb_read(32'h8, rd, err, rdy); check(rd);

        expect_val("order_violations", 32'h0);
        check(32'(viol));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
